ili_spi_slave: RTL and testbench
================================

ILI_SPI_SLAVE -- requirements
Module: ili_spi_slave

Interface
REQ-001 Parameter FIFO_DEPTH, default 4, meaning: received-byte FIFO entries; power of two, 2..16.
REQ-002 Parameter ID_VALUE, default 24'h009341, meaning: display ID returned by RDDID readback.
REQ-003 clk  input  1  single system clock; all logic on its rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 sclk  input  1  SPI serial clock from master, asynchronous to clk, idle low (mode 0).
REQ-006 mosi  input  1  serial data from master, MSB first.
REQ-007 cs  input  1  chip select, active low.
REQ-008 dc  input  1  0 = command byte, 1 = data byte.
REQ-009 miso  output  1  serial readback data to master.
REQ-010 o_byte  output  9  FIFO head, {dc, value[7:0]}.
REQ-011 o_valid  output  1  FIFO non-empty.
REQ-012 i_ready  input  1  consumer accepts o_byte when o_valid & i_ready.
REQ-013 o_overflow  output  1  sticky: a byte was dropped because the FIFO was full.
REQ-014 o_frame_err  output  1  one-cycle pulse: cs deasserted mid-byte.
REQ-015 o_cmd_count  output  16  count of command bytes (dc=0) received.

Function
REQ-016 sclk, mosi, cs and dc SHALL each pass through a 2-FF synchronizer before use.
REQ-017 Rising edge SHALL be detected as sync_sclk & ~sclk_prev, and falling edge as ~sync_sclk & sclk_prev.
REQ-018 On each rising edge with synced cs low, the synced mosi bit SHALL shift into the shift register and the 3-bit bit counter SHALL increment.
REQ-019 On the 8th bit, the byte is {synced dc, shreg[6:0], mosi}; it SHALL be written to the FIFO on the same clk edge, so o_valid rises at the 3rd clk edge after the raw 8th sclk rise.
REQ-020 The FIFO SHALL be show-ahead: o_byte is valid whenever o_valid = 1, and a pop on o_valid & i_ready takes effect at that clk edge.
REQ-021 Write when full without a same-cycle pop: byte dropped, FIFO unchanged, o_overflow set until rst.
REQ-022 Write when full with a same-cycle pop: both SHALL succeed, and count is unchanged.
REQ-023 Pop when empty SHALL be ignored.
REQ-024 Synced cs going high with bit counter != 0: counter cleared, partial byte discarded, o_frame_err pulsed for 1 cycle.
REQ-025 Synced cs going high with counter == 0: counter stays 0, no pulse.
REQ-026 While synced cs is high, sclk edges SHALL be ignored.
REQ-027 o_cmd_count SHALL increment for every completed dc=0 byte, including bytes dropped on overflow, and wrap 16'hFFFF -> 0.
REQ-028 The readback FSM SHALL have states IDLE, RD_SHIFT.
REQ-029 IDLE -> RD_SHIFT when a completed command byte equals RDDID (8'h04); miso is then loaded with bit 31 of {8'h00, ID_VALUE}.
REQ-030 In RD_SHIFT, each falling sclk edge SHALL advance miso to the next bit; after 32 bits the FSM returns to IDLE.
REQ-031 In RD_SHIFT, synced cs high SHALL force IDLE immediately.
REQ-032 miso SHALL be 0 in IDLE.
REQ-033 Bytes received during RD_SHIFT SHALL still be captured into the FIFO normally.

Reset
REQ-034 While rst = 1: FIFO empty, o_valid 0, o_byte 9'h000, o_overflow 0, o_frame_err 0, o_cmd_count 0, miso 0, FSM IDLE, bit counter 0, synchronizers 0, sclk_prev 0.
REQ-035 rst asserted mid-byte or mid-readback SHALL abandon the transfer; no byte is written after release.

Configuration
REQ-036 Macro ILI_SLV_READBACK_EN: when defined, REQ-028..REQ-033 apply.
REQ-037 When ILI_SLV_READBACK_EN is undefined: no readback FSM, miso tied to 0, ID_VALUE unused, RDDID treated as an ordinary command byte.

Structure
REQ-038 pkg_ili9341 SHALL hold the constant C_RDDID = 8'h04 and the typedef st_slv_byte {logic dc; logic [7:0] val}.
REQ-039 o_byte SHALL carry st_slv_byte.
REQ-040 The FIFO SHALL be the sub-module slv_byte_fifo, parameterised by FIFO_DEPTH, with ports push, pop, din, dout, full, empty.

Verification
REQ-041 Send command 8'h2A then data 8'h55, i_ready=1 -> o_byte 9'h02A then 9'h155, o_cmd_count=1.
REQ-042 i_ready=0, send 5 bytes at FIFO_DEPTH=4 -> o_valid=1, o_overflow=1, pops return the first 4 bytes, o_cmd_count per dc.
REQ-043 Raise cs after 5 bits -> o_frame_err 1-cycle pulse, nothing written; next full byte 8'hA5 is received correctly.
REQ-044 Macro defined, send command 8'h04, then clock 32 bits -> miso sequence 8'h00, 8'h00, 8'h93, 8'h41 MSB first; miso 0 afterwards.
REQ-045 Assert rst after 12 of 32 readback bits -> miso 0, FSM IDLE, FIFO empty; after release, a new 8'h04 restarts readback from bit 31.
REQ-046 With FIFO full and i_ready=1 while a byte completes -> no overflow, occupancy unchanged, order preserved.

Source files
------------

// File: rtl/ili_spi_slave_pkg.sv
// rtl/ili_spi_slave_pkg.sv - shared constants and types for the ILI9341-style SPI slave
package pkg_ili9341;

   localparam logic [7:0] C_RDDID = 8'h04;

   typedef struct packed {
      logic       dc;
      logic [7:0] val;
   } st_slv_byte;

   typedef enum logic {
      IDLE,
      RD_SHIFT
   } st_rd_state;

endpackage

// File: rtl/ili_spi_slave_fifo.sv
// rtl/ili_spi_slave_fifo.sv - show-ahead received-byte FIFO (module slv_byte_fifo)
module slv_byte_fifo
   import pkg_ili9341::*;
#(
   parameter int FIFO_DEPTH = 4
)(
   input  logic       clk,
   input  logic       rst,
   input  logic       push,
   input  logic       pop,
   input  st_slv_byte din,
   output st_slv_byte dout,
   output logic       full,
   output logic       empty
);

   localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam logic [AW:0] FULL_CNT = FIFO_DEPTH[AW:0];

   st_slv_byte     mem [FIFO_DEPTH];
   logic [AW-1:0]  wr_ptr;
   logic [AW-1:0]  rd_ptr;
   logic [AW:0]    count;
   logic           do_push;
   logic           do_pop;

   // a write into a full FIFO still lands when the head leaves on the same edge
   assign do_pop  = pop & ~empty;
   assign do_push = push & (~full | do_pop);
   assign empty   = (count == '0);
   assign full    = (count == FULL_CNT);
   assign dout    = empty ? '0 : mem[rd_ptr];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= din;
   end

endmodule

// File: rtl/ili_spi_slave.sv
// rtl/ili_spi_slave.sv - mode-0 SPI slave for ILI9341 command/data bytes; RDDID readback under ILI_SLV_READBACK_EN
module ili_spi_slave
   import pkg_ili9341::*;
#(
   parameter int          FIFO_DEPTH = 4,
   parameter logic [23:0] ID_VALUE   = 24'h009341
)(
   input  logic        clk,
   input  logic        rst,
   input  logic        sclk,
   input  logic        mosi,
   input  logic        cs,
   input  logic        dc,
   output logic        miso,
   output st_slv_byte  o_byte,
   output logic        o_valid,
   input  logic        i_ready,
   output logic        o_overflow,
   output logic        o_frame_err,
   output logic [15:0] o_cmd_count
);

   logic [1:0] sclk_ff, mosi_ff, cs_ff, dc_ff;
   logic       sclk_s, mosi_s, cs_s, dc_s;
   logic       sclk_prev;
   logic       rise;
   logic [2:0] bit_cnt;
   logic [6:0] shreg;
   logic       byte_done;
   st_slv_byte new_byte;
   logic       pop;
   logic       fifo_full;
   logic       fifo_empty;

   assign sclk_s = sclk_ff[1];
   assign mosi_s = mosi_ff[1];
   assign cs_s   = cs_ff[1];
   assign dc_s   = dc_ff[1];
   assign rise   = sclk_s & ~sclk_prev;

   assign byte_done = rise & ~cs_s & (bit_cnt == 3'd7);
   assign new_byte  = '{dc: dc_s, val: {shreg, mosi_s}};
   assign o_valid   = ~fifo_empty;
   assign pop       = o_valid & i_ready;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sclk_ff     <= '0;
         mosi_ff     <= '0;
         cs_ff       <= '0;
         dc_ff       <= '0;
         sclk_prev   <= 1'b0;
         bit_cnt     <= '0;
         shreg       <= '0;
         o_overflow  <= 1'b0;
         o_frame_err <= 1'b0;
         o_cmd_count <= '0;
      end else begin
         sclk_ff     <= {sclk_ff[0], sclk};
         mosi_ff     <= {mosi_ff[0], mosi};
         cs_ff       <= {cs_ff[0], cs};
         dc_ff       <= {dc_ff[0], dc};
         sclk_prev   <= sclk_s;
         o_frame_err <= 1'b0;
         if (cs_s) begin
            if (bit_cnt != 3'd0) begin
               bit_cnt     <= '0;
               o_frame_err <= 1'b1;
            end
         end else if (rise) begin
            shreg   <= {shreg[5:0], mosi_s};
            bit_cnt <= bit_cnt + 3'd1;
         end
         // dropped command bytes still count
         if (byte_done && !dc_s) o_cmd_count <= o_cmd_count + 16'd1;
         if (byte_done && fifo_full && !pop) o_overflow <= 1'b1;
      end
   end

   slv_byte_fifo #(
      .FIFO_DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (byte_done),
      .pop   (pop),
      .din   (new_byte),
      .dout  (o_byte),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

`ifdef ILI_SLV_READBACK_EN
   localparam logic [31:0] RD_WORD = {8'h00, ID_VALUE};

   st_rd_state rd_state;
   logic [31:0] rd_sr;
   logic [4:0]  rd_cnt;
   logic        rd_hold;
   logic        fall;

   assign fall = ~sclk_s & sclk_prev;

   // the fall closing the RDDID byte only presents bit 31; the next 32 falls walk the word
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_state <= IDLE;
         rd_sr    <= '0;
         rd_cnt   <= '0;
         rd_hold  <= 1'b0;
         miso     <= 1'b0;
      end else begin
         case (rd_state)
            IDLE: begin
               miso <= 1'b0;
               if (byte_done && !dc_s && new_byte.val == C_RDDID) begin
                  rd_state <= RD_SHIFT;
                  miso     <= RD_WORD[31];
                  rd_sr    <= {RD_WORD[30:0], 1'b0};
                  rd_cnt   <= '0;
                  rd_hold  <= 1'b1;
               end
            end
            RD_SHIFT: begin
               if (cs_s) begin
                  rd_state <= IDLE;
                  miso     <= 1'b0;
               end else if (fall) begin
                  if (rd_hold) begin
                     rd_hold <= 1'b0;
                  end else if (rd_cnt == 5'd31) begin
                     rd_state <= IDLE;
                     miso     <= 1'b0;
                  end else begin
                     miso   <= rd_sr[31];
                     rd_sr  <= {rd_sr[30:0], 1'b0};
                     rd_cnt <= rd_cnt + 5'd1;
                  end
               end
            end
            default: begin
               rd_state <= IDLE;
               miso     <= 1'b0;
            end
         endcase
      end
   end
`else
   logic unused_id;
   assign unused_id = ^ID_VALUE;
   assign miso      = 1'b0;
`endif

endmodule

// File: tb/tb_ili_spi_slave.sv
// tb/tb_ili_spi_slave.sv - randomized self-checking bench for ili_spi_slave against a queue model
module tb_ili_spi_slave;
   import pkg_ili9341::*;

   localparam int          DEPTH = 4;
   localparam logic [23:0] ID    = 24'h009341;
`ifdef ILI_SLV_READBACK_EN
   localparam logic [31:0] RD_WORD = {8'h00, ID};
`else
   localparam logic [31:0] RD_WORD = 32'h0;
`endif

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        sclk = 1'b0;
   logic        mosi = 1'b0;
   logic        cs = 1'b1;
   logic        dc = 1'b0;
   logic        i_ready = 1'b0;
   logic        miso;
   st_slv_byte  o_byte;
   logic        o_valid;
   logic        o_overflow;
   logic        o_frame_err;
   logic [15:0] o_cmd_count;

   int n_checks = 0;
   int n_fail   = 0;

   logic [8:0] mq[$];
   logic [8:0] exp_out[$];
   logic [8:0] obs[$];
   logic       m_ovf = 1'b0;
   int         m_cmd = 0;
   int         m_fe  = 0;
   int         fe_cycles = 0;

   always #5 clk = ~clk;

   ili_spi_slave #(
      .FIFO_DEPTH (DEPTH),
      .ID_VALUE   (ID)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .sclk        (sclk),
      .mosi        (mosi),
      .cs          (cs),
      .dc          (dc),
      .miso        (miso),
      .o_byte      (o_byte),
      .o_valid     (o_valid),
      .i_ready     (i_ready),
      .o_overflow  (o_overflow),
      .o_frame_err (o_frame_err),
      .o_cmd_count (o_cmd_count)
   );

   always @(negedge clk) begin
      if (o_valid && i_ready) obs.push_back(o_byte);
      if (o_frame_err) fe_cycles++;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic model_reset();
      mq.delete();
      exp_out.delete();
      obs.delete();
      m_ovf = 1'b0;
      m_cmd = 0;
   endtask

   task automatic model_write(input logic [8:0] b, input bit pop_same);
      if (!b[8]) m_cmd = (m_cmd + 1) % 65536;
      if (pop_same && mq.size() > 0) exp_out.push_back(mq.pop_front());
      if (mq.size() < DEPTH) mq.push_back(b);
      else m_ovf = 1'b1;
   endtask

   task automatic model_drain();
      while (mq.size() > 0) exp_out.push_back(mq.pop_front());
   endtask

   task automatic spi_bit(input logic b, input bit pop_on_edge, output logic m);
      mosi = b;
      tick(3);
      sclk = 1'b1;
      if (pop_on_edge) begin
         tick(2);
         i_ready = 1'b1;
         tick(1);
         i_ready = 1'b0;
         tick(1);
      end else begin
         tick(4);
      end
      m = miso;
      sclk = 1'b0;
      tick(1);
   endtask

   task automatic send_byte(input logic d, input logic [7:0] v, input bit pop_last);
      logic m;
      dc = d;
      cs = 1'b0;
      for (int i = 0; i < 8; i++) spi_bit(v[7-i], pop_last && (i == 7), m);
      model_write({d, v}, pop_last);
      if (i_ready) model_drain();
   endtask

   task automatic rd_clock(input int nbits, output logic [31:0] got);
      logic [7:0] v;
      logic       m;
      got = '0;
      v   = '0;
      dc  = 1'b1;
      cs  = 1'b0;
      for (int k = 0; k < nbits; k++) begin
         if (k % 8 == 0) v = 8'($urandom);
         spi_bit(v[7 - (k % 8)], 1'b0, m);
         got = {got[30:0], m};
         if (k % 8 == 7) begin
            model_write({1'b1, v}, 1'b0);
            if (i_ready) model_drain();
         end
      end
   endtask

   task automatic drain();
      i_ready = 1'b1;
      tick(DEPTH + 4);
      model_drain();
   endtask

   task automatic compare_stream(input string tag);
      logic [31:0] g;
      check({tag, "_count"}, 32'(obs.size()), 32'(exp_out.size()));
      for (int i = 0; i < exp_out.size(); i++) begin
         g = (i < obs.size()) ? 32'(obs[i]) : 32'hDEADBEEF;
         check({tag, "_byte"}, g, 32'(exp_out[i]));
      end
      obs.delete();
      exp_out.delete();
   endtask

   task automatic check_status(input string tag);
      check({tag, "_cmd_count"}, 32'(o_cmd_count), 32'(m_cmd));
      check({tag, "_overflow"},  32'(o_overflow),  32'(m_ovf));
      check({tag, "_frame_err"}, 32'(fe_cycles),   32'(m_fe));
   endtask

   initial begin
      logic [31:0] g;
      logic [31:0] exp12;
      logic        m;
      int          nb;

      // reset state
      tick(4);
      check("rst_valid", 32'(o_valid), 32'h0);
      check("rst_byte", 32'(o_byte), 32'h0);
      check("rst_miso", 32'(miso), 32'h0);
      check_status("rst");
      rst = 1'b0;
      tick(4);

      // command then data with consumer ready
      i_ready = 1'b1;
      send_byte(1'b0, 8'h2A, 1'b0);
      send_byte(1'b1, 8'h55, 1'b0);
      tick(4);
      compare_stream("cmd_data");
      check_status("cmd_data");

      // cs raised mid-byte
      cs = 1'b0;
      for (int i = 0; i < 5; i++) spi_bit(1'($urandom), 1'b0, m);
      cs = 1'b1;
      m_fe++;
      tick(6);
      check("frame_valid", 32'(o_valid), 32'h0);
      check_status("frame");
      send_byte(1'($urandom), 8'hA5, 1'b0);
      tick(4);
      compare_stream("after_frame");
      cs = 1'b1;
      tick(4);
      check_status("frame_clean_cs");

      // full FIFO with a pop on the completing edge
      i_ready = 1'b0;
      for (int i = 0; i < DEPTH; i++) send_byte(1'($urandom), 8'($urandom), 1'b0);
      check("full_valid", 32'(o_valid), 32'h1);
      send_byte(1'($urandom), 8'($urandom), 1'b1);
      tick(2);
      check_status("full_pop");
      drain();
      compare_stream("full_pop");

      // overflow: one byte past capacity
      i_ready = 1'b0;
      for (int i = 0; i < DEPTH + 1; i++) send_byte(1'($urandom), 8'($urandom), 1'b0);
      tick(2);
      check("ovf_valid", 32'(o_valid), 32'h1);
      check_status("ovf");
      drain();
      compare_stream("ovf");
      check_status("ovf_sticky");

      // RDDID readback; data bytes clocked meanwhile are still captured
      i_ready = 1'b1;
      send_byte(1'b0, C_RDDID, 1'b0);
      rd_clock(32, g);
      check("rd_word", g, RD_WORD);
      tick(4);
      check("rd_miso_after", 32'(miso), 32'h0);
      compare_stream("rd_bytes");
      check_status("rd");

      // reset in the middle of a readback
      send_byte(1'b0, C_RDDID, 1'b0);
      rd_clock(12, g);
      exp12 = 32'(RD_WORD[31:20]);
      check("rd12_word", {20'h0, g[11:0]}, exp12);
      tick(2);
      compare_stream("rd12_bytes");
      rst = 1'b1;
      tick(2);
      check("rdrst_miso", 32'(miso), 32'h0);
      check("rdrst_valid", 32'(o_valid), 32'h0);
      model_reset();
      check_status("rdrst");
      rst = 1'b0;
      tick(20);
      check("rdrst_no_write", 32'(o_valid), 32'h0);
      send_byte(1'b0, C_RDDID, 1'b0);
      rd_clock(32, g);
      check("rd_restart_word", g, RD_WORD);
      tick(4);
      check("rd_restart_miso", 32'(miso), 32'h0);
      compare_stream("rd_restart");
      cs = 1'b1;
      tick(4);

      // random traffic with occasional aborted bytes and cs gaps
      i_ready = 1'b1;
      for (int it = 0; it < 30; it++) begin
         if ($urandom_range(5) == 0) begin
            nb = $urandom_range(7, 1);
            cs = 1'b0;
            for (int i = 0; i < nb; i++) spi_bit(1'($urandom), 1'b0, m);
            cs = 1'b1;
            m_fe++;
            tick(5);
         end else begin
            send_byte(1'($urandom), 8'($urandom), 1'b0);
            if ($urandom_range(2) == 0) begin
               cs = 1'b1;
               tick(4);
            end
         end
      end
      cs = 1'b1;
      tick(6);
      compare_stream("random");
      check_status("random");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
